// File: rtl/exu_csr_pkg.sv
// rtl/exu_csr_pkg.sv - shared types and helpers for the CSR execute unit
// Contents: csr_op_e operation encoding, csr_entry_t result-queue entry,
//           entry field widths and the CSR read-modify-write helper.
package exu_csr_pkg;

  localparam int CSR_OP_W       = 2;
  localparam int ENT_DATA_W     = 32;
  localparam int ENT_CSR_ADDR_W = 12;
  localparam int ENT_REG_ADDR_W = 5;
  localparam int ENT_ID_W       = 4;

  typedef enum logic [CSR_OP_W-1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_e;

  typedef struct packed {
    logic                      csr_we;
    logic [ENT_CSR_ADDR_W-1:0] csr_waddr;
    logic [ENT_DATA_W-1:0]     csr_wdata;
    logic                      reg_we;
    logic [ENT_REG_ADDR_W-1:0] reg_waddr;
    logic [ENT_DATA_W-1:0]     reg_wdata;
    logic [ENT_ID_W-1:0]       commit_id;
  } csr_entry_t;

  // New CSR value from the old value and the operand.
  function automatic logic [ENT_DATA_W-1:0] csr_alu(
    input csr_op_e               op,
    input logic [ENT_DATA_W-1:0] old_val,
    input logic [ENT_DATA_W-1:0] op1
  );
    case (op)
      CSR_RS:  csr_alu = old_val | op1;
      CSR_RC:  csr_alu = old_val & ~op1;
      default: csr_alu = op1;
    endcase
  endfunction

endpackage

// File: rtl/csr_fwd_fifo.sv
// rtl/csr_fwd_fifo.sv - in-order result FIFO exposing every slot for forwarding
// Ports: clk/rst (sync, active-high); push_i/entry_i enqueue; pop_i dequeue head;
//        head_o oldest entry; entries_o/valid_o raw slots and occupancy mask;
//        count_o number of entries; rd_ptr_o slot index of the oldest entry.
module csr_fwd_fifo
  import exu_csr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  csr_entry_t       entry_i,
  input  logic             pop_i,
  output csr_entry_t       head_o,
  output csr_entry_t       entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic [PTR_W-1:0] rd_ptr_o
);

  csr_entry_t       mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Payload carries no reset; vld_q alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // Pop clears before push sets so a full-queue refill of the same slot stays valid.
      if (pop_i) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= ptr_inc(rd_ptr_q);
      end
      if (push_i) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign valid_o   = vld_q;
  assign count_o   = cnt_q;
  assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/exu_csr_pipe.sv
// rtl/exu_csr_pipe.sv - CSR execute unit with forwarding result queue toward writeback
// Ports: dispatch side req_valid_i/req_ready_o/csr_stall_o with op, operand, CSR read
//        data, rd and commit ID; int_assert_i squashes the offered op; writeback side
//        wb_valid_o/wb_ready_i with head CSR/GPR write fields; occupancy_o queue fill.
module exu_csr_pipe
  import exu_csr_pkg::*;
#(
  parameter int DATA_W     = ENT_DATA_W,
  parameter int CSR_ADDR_W = ENT_CSR_ADDR_W,
  parameter int REG_ADDR_W = ENT_REG_ADDR_W,
  parameter int ID_W       = ENT_ID_W,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  csr_op_e               csr_op_i,
  input  logic [DATA_W-1:0]     op1_i,
  input  logic                  op1_zero_i,
  input  logic [CSR_ADDR_W-1:0] csr_addr_i,
  input  logic [DATA_W-1:0]     csr_rdata_i,
  input  logic                  reg_we_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic [ID_W-1:0]       commit_id_i,
  input  logic                  int_assert_i,
  output logic                  csr_stall_o,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0]     csr_wdata_o,
  output logic                  reg_we_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0]     reg_wdata_o,
  output logic [ID_W-1:0]       commit_id_o,
  output logic [CNT_W-1:0]      occupancy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  csr_entry_t       entries [DEPTH];
  csr_entry_t       head, new_entry;
  logic [DEPTH-1:0] vld;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] old_val;
  logic             deq, acc;

  assign wb_valid_o  = (count != '0);
  assign deq         = wb_valid_o & wb_ready_i;
  assign req_ready_o = (count < CNT_W'(DEPTH)) | deq;
  assign csr_stall_o = req_valid_i & ~req_ready_o;
  assign acc         = req_valid_i & req_ready_o & ~int_assert_i & (csr_op_i != CSR_NONE);

  // Walk oldest to youngest so the last hit is the youngest pending write.
  // The head is still valid during its dequeue cycle, so it keeps forwarding.
  always_comb begin
    int slot;
    old_val = csr_rdata_i;
    for (int k = 0; k < DEPTH; k++) begin
      slot = int'(rd_ptr) + k;
      if (slot >= DEPTH) slot = slot - DEPTH;
      if (vld[PTR_W'(slot)] && entries[PTR_W'(slot)].csr_we &&
          entries[PTR_W'(slot)].csr_waddr == csr_addr_i)
        old_val = entries[PTR_W'(slot)].csr_wdata;
    end
  end

  always_comb begin
    new_entry           = '0;
    // Set/clear with a zero operand is a pure read and must not write the CSR.
    new_entry.csr_we    = (csr_op_i == CSR_RW) | ~op1_zero_i;
    new_entry.csr_waddr = csr_addr_i;
    new_entry.csr_wdata = csr_alu(csr_op_i, old_val, op1_i);
    new_entry.reg_we    = reg_we_i;
    new_entry.reg_waddr = reg_waddr_i;
    new_entry.reg_wdata = old_val;
    new_entry.commit_id = commit_id_i;
  end

  csr_fwd_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (acc),
    .entry_i   (new_entry),
    .pop_i     (deq),
    .head_o    (head),
    .entries_o (entries),
    .valid_o   (vld),
    .count_o   (count),
    .rd_ptr_o  (rd_ptr)
  );

  // Head fields are forced to zero while the queue is empty.
  assign csr_we_o    = wb_valid_o & head.csr_we;
  assign csr_waddr_o = wb_valid_o ? head.csr_waddr : '0;
  assign csr_wdata_o = wb_valid_o ? head.csr_wdata : '0;
  assign reg_we_o    = wb_valid_o & head.reg_we;
  assign reg_waddr_o = wb_valid_o ? head.reg_waddr : '0;
  assign reg_wdata_o = wb_valid_o ? head.reg_wdata : '0;
  assign commit_id_o = wb_valid_o ? head.commit_id : '0;
  assign occupancy_o = count;

endmodule

// File: tb/tb_exu_csr_pipe.sv
// tb/tb_exu_csr_pipe.sv - self-checking bench for exu_csr_pipe
module tb_exu_csr_pipe;
  import exu_csr_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  csr_op_e     csr_op = CSR_NONE;
  logic [31:0] op1 = '0;
  logic        op1_zero = 1'b1;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_rdata = '0;
  logic        reg_we = 1'b0;
  logic [4:0]  reg_waddr = '0;
  logic [3:0]  commit_id = '0;
  logic        int_assert = 1'b0;
  logic        csr_stall;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  commit_id_o;
  logic [CNT_W-1:0] occupancy;

  always #5 clk = ~clk;

  exu_csr_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .csr_op_i(csr_op), .op1_i(op1), .op1_zero_i(op1_zero),
    .csr_addr_i(csr_addr), .csr_rdata_i(csr_rdata),
    .reg_we_i(reg_we), .reg_waddr_i(reg_waddr), .commit_id_i(commit_id),
    .int_assert_i(int_assert), .csr_stall_o(csr_stall),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .commit_id_o(commit_id_o), .occupancy_o(occupancy)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a list of pending results, youngest at the back.
  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    bit          rwe;
    logic [4:0]  rwa;
    logic [31:0] rwd;
    logic [3:0]  id;
  } m_t;
  m_t mq[$];

  always @(posedge clk) begin
    bit deq, rdy, acc, found;
    m_t e;
    logic [31:0] old;
    if (rst) begin
      mq.delete();
    end else begin
      deq = (mq.size() > 0) && wb_ready;
      rdy = (mq.size() < DEPTH) || deq;
      acc = req_valid && rdy && !int_assert && (csr_op != CSR_NONE);
      if (acc) begin
        old = csr_rdata;
        found = 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (!found && mq[i].we && mq[i].addr == csr_addr) begin
            old = mq[i].wdata;
            found = 1'b1;
          end
        end
        e.we    = (csr_op == CSR_RW) || !op1_zero;
        e.addr  = csr_addr;
        if (csr_op == CSR_RW)      e.wdata = op1;
        else if (csr_op == CSR_RS) e.wdata = old | op1;
        else                       e.wdata = old & ~op1;
        e.rwe   = reg_we;
        e.rwa   = reg_waddr;
        e.rwd   = old;
        e.id    = commit_id;
      end
      if (deq) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
  end

  // Compare process: every negedge once the bench is out of initial reset.
  always @(negedge clk) begin
    bit ne, exp_rdy;
    if (started) begin
      ne = mq.size() > 0;
      exp_rdy = (mq.size() < DEPTH) || (ne && wb_ready);
      chk("wb_valid",    64'(wb_valid),    64'(ne));
      chk("occupancy",   64'(occupancy),   64'(mq.size()));
      chk("req_ready",   64'(req_ready),   64'(exp_rdy));
      chk("csr_stall",   64'(csr_stall),   64'(req_valid && !exp_rdy));
      chk("csr_we",      64'(csr_we_o),    ne ? 64'(mq[0].we)    : 64'(0));
      chk("csr_waddr",   64'(csr_waddr_o), ne ? 64'(mq[0].addr)  : 64'(0));
      chk("csr_wdata",   64'(csr_wdata_o), ne ? 64'(mq[0].wdata) : 64'(0));
      chk("reg_we",      64'(reg_we_o),    ne ? 64'(mq[0].rwe)   : 64'(0));
      chk("reg_waddr",   64'(reg_waddr_o), ne ? 64'(mq[0].rwa)   : 64'(0));
      chk("reg_wdata",   64'(reg_wdata_o), ne ? 64'(mq[0].rwd)   : 64'(0));
      chk("commit_id",   64'(commit_id_o), ne ? 64'(mq[0].id)    : 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input csr_op_e op, input logic [31:0] v, input logic [11:0] a,
                       input logic [31:0] rd, input logic [3:0] id);
    req_valid = 1'b1;
    csr_op    = op;
    op1       = v;
    op1_zero  = (v == 32'd0);
    csr_addr  = a;
    csr_rdata = rd;
    reg_we    = 1'b1;
    reg_waddr = 5'(id) + 5'd1;
    commit_id = id;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
    #1;
    chk("L reset wb_valid", 64'(wb_valid), 64'(0));
    chk("L reset occ", 64'(occupancy), 64'(0));

    // 1: RW, pass-through
    wb_ready = 1'b1;
    offer(CSR_RW, 32'h8, 12'h300, 32'h1800, 4'd1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("L1 csr_we", 64'(csr_we_o), 64'(1));
    chk("L1 wdata", 64'(csr_wdata_o), 64'h8);
    chk("L1 reg_wdata", 64'(reg_wdata_o), 64'h1800);
    chk("L1 occ", 64'(occupancy), 64'(1));
    tick();

    // 2: RS with zero operand does not write
    offer(CSR_RS, 32'h0, 12'h300, 32'h88, 4'd2);
    tick();
    req_valid = 1'b0;
    #1;
    chk("L2 csr_we", 64'(csr_we_o), 64'(0));
    chk("L2 reg_wdata", 64'(reg_wdata_o), 64'h88);
    tick();

    // 3: forwarding from a held entry
    wb_ready = 1'b0;
    offer(CSR_RW, 32'h100, 12'h305, 32'h55, 4'd3);
    tick();
    offer(CSR_RS, 32'h3, 12'h305, 32'h0, 4'd4);
    tick();
    req_valid = 1'b0;
    #1;
    chk("L3 occ", 64'(occupancy), 64'(2));
    chk("L3 head wdata", 64'(csr_wdata_o), 64'h100);
    wb_ready = 1'b1;
    tick();
    #1;
    chk("L3 2nd id", 64'(commit_id_o), 64'(4));
    chk("L3 2nd wdata", 64'(csr_wdata_o), 64'h103);
    chk("L3 2nd reg_wdata", 64'(reg_wdata_o), 64'h100);
    tick();

    // 4: full queue stalls, then accepts on same-cycle dequeue
    wb_ready = 1'b0;
    offer(CSR_RW, 32'hF0, 12'h340, 32'h0, 4'd5);
    tick();
    offer(CSR_RC, 32'h30, 12'h340, 32'hFFFF, 4'd6);
    tick();
    offer(CSR_RC, 32'h40, 12'h340, 32'hFFFF, 4'd7);
    #1;
    chk("L4 stall", 64'(csr_stall), 64'(1));
    chk("L4 occ", 64'(occupancy), 64'(2));
    tick();
    #1;
    chk("L4 stall held", 64'(csr_stall), 64'(1));
    chk("L4 head id", 64'(commit_id_o), 64'(5));
    wb_ready = 1'b1;
    #1;
    chk("L4 ready on deq", 64'(req_ready), 64'(1));
    chk("L4 no stall", 64'(csr_stall), 64'(0));
    tick();
    req_valid = 1'b0;
    #1;
    chk("L4 id6", 64'(commit_id_o), 64'(6));
    chk("L4 id6 wdata", 64'(csr_wdata_o), 64'hC0);
    chk("L4 occ2", 64'(occupancy), 64'(2));
    tick();
    #1;
    chk("L4 id7", 64'(commit_id_o), 64'(7));
    chk("L4 id7 wdata", 64'(csr_wdata_o), 64'h80);
    chk("L4 id7 reg_wdata", 64'(reg_wdata_o), 64'hC0);
    tick();

    // 5: interrupt squashes the offered op
    offer(CSR_RC, 32'h1, 12'h300, 32'h3, 4'd8);
    int_assert = 1'b1;
    tick();
    int_assert = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("L5 wb_valid", 64'(wb_valid), 64'(0));
    chk("L5 occ", 64'(occupancy), 64'(0));

    // 6: reset with a full queue, then 1-cycle latency and same-cycle head forwarding
    wb_ready = 1'b0;
    offer(CSR_RW, 32'h11, 12'h301, 32'h0, 4'd9);
    tick();
    offer(CSR_RW, 32'h22, 12'h302, 32'h0, 4'd10);
    tick();
    req_valid = 1'b0;
    #1;
    chk("L6 occ full", 64'(occupancy), 64'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("L6 wb_valid", 64'(wb_valid), 64'(0));
    chk("L6 occ", 64'(occupancy), 64'(0));
    chk("L6 wdata", 64'(csr_wdata_o), 64'(0));
    chk("L6 id", 64'(commit_id_o), 64'(0));
    wb_ready = 1'b1;
    offer(CSR_RW, 32'hA0, 12'h310, 32'h7, 4'd11);
    tick();
    #1;
    chk("L6 latency valid", 64'(wb_valid), 64'(1));
    chk("L6 latency id", 64'(commit_id_o), 64'(11));
    chk("L6 reg_wdata", 64'(reg_wdata_o), 64'h7);
    offer(CSR_RS, 32'h5, 12'h310, 32'h0, 4'd12);
    tick();
    req_valid = 1'b0;
    #1;
    chk("L6 fwd wdata", 64'(csr_wdata_o), 64'hA5);
    chk("L6 fwd reg_wdata", 64'(reg_wdata_o), 64'hA0);
    chk("L6 fwd occ", 64'(occupancy), 64'(1));
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
